// File: rtl/add_arb2_if.sv
// Request/response bundle for the two-requester shared add/sub unit.
// master drives requests and consumes responses; slave is the unit.
interface add_arb2_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_sub;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_s;
  logic        rsp_co;
  logic        rsp_ov;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_co, rsp_ov
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_co, rsp_ov
  );
endinterface

// File: rtl/add_arb2.sv
// Two requesters share one 32-bit CLA adder via round-robin arbitration.
// One registered response slot: 1-cycle latency, 1 op/cycle throughput.
module cla32_ov (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co,
  output logic        ov
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic        gg;
  logic        pg;

  // 4-bit lookahead groups chained on their group generate/propagate
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    gg   = 1'b0;
    pg   = 1'b0;
    c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & c[4*k]);
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1]
            & g[4*k]);
      pg = &p[4*k +: 4];
      c[4*k+4] = gg | (pg & c[4*k]);
    end
  end

  assign s  = p ^ c[31:0];
  assign co = c[32];
  assign ov = c[31] ^ c[32];
endmodule

module add_arb2 (
  input  logic      clk,
  input  logic      reset_n,
  add_arb2_if.slave bus
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        last_q;
  logic        free;
  logic        gnt0;
  logic        gnt1;
  logic        gnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic [31:0] sum;
  logic        co;
  logic        ov;
  logic [31:0] s_q;
  logic        co_q;
  logic        ov_q;
  logic        id_q;

  assign free = (state_q == EMPTY) | bus.rsp_ready;

  // last_q=1 means requester 1 won last, so requester 0 is favoured
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && free) begin
      unique case (1'b1)
        (bus.req0_valid & bus.req1_valid): begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end
        (bus.req0_valid & ~bus.req1_valid): gnt0 = 1'b1;
        (~bus.req0_valid & bus.req1_valid): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt    = gnt0 | gnt1;
  assign op_a   = gnt1 ? bus.req1_a   : bus.req0_a;
  assign op_b   = gnt1 ? bus.req1_b   : bus.req0_b;
  assign op_sub = gnt1 ? bus.req1_sub : bus.req0_sub;

  cla32_ov u_cla (
    .a  (op_a),
    .b  (op_sub ? ~op_b : op_b),
    .ci (op_sub),
    .s  (sum),
    .co (co),
    .ov (ov)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        last_q <= gnt1;
        s_q    <= sum;
        co_q   <= co;
        ov_q   <= ov;
        id_q   <= gnt1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (gnt) state_d = FULL;
      FULL: begin
        if (gnt)                state_d = FULL;
        else if (bus.rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.rsp_valid  = (state_q == FULL);
    bus.rsp_id     = id_q;
    bus.rsp_s      = s_q;
    bus.rsp_co     = co_q;
    bus.rsp_ov     = ov_q;
  end
endmodule
